// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the hazard scoreboard.
package hazard_pkg;

  localparam int unsigned NREG_DEF    = 32;
  localparam int unsigned MDU_LAT_DEF = 4;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/mdu_tracker.sv
// Tracks the one in-flight multi-cycle op: countdown to write-back plus its destination.
module mdu_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEF,
  parameter int unsigned REGW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [REGW-1:0] dest,
  output logic [REGW-1:0] mdu_reg,
  output logic            busy,
  output logic            done
);

  if (MDU_LAT < 2 || MDU_LAT > 15) begin : g_bad_lat
    $error("mdu_tracker: MDU_LAT must be within 2..15");
  end

  logic [CNT_W-1:0] cnt;

  // A new issue always reloads; an old op at cnt==1 still reports done this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mdu_reg <= '0;
    end else if (start) begin
      cnt     <= CNT_W'(MDU_LAT);
      mdu_reg <= dest;
    end else if (cnt != '0) begin
      cnt     <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(start && cnt > CNT_W'(1)));

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline forwarding and stall control with multi-cycle-op tracking.
// Define HAZARD_PERF_EN to add the saturating StallCount performance counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG    = NREG_DEF,
  parameter int unsigned MDU_LAT = MDU_LAT_DEF,
  parameter int unsigned PERF_W  = 32,
  localparam int unsigned REGW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REGW-1:0]   rsD,
  input  logic [REGW-1:0]   rtD,
  input  logic [REGW-1:0]   rsE,
  input  logic [REGW-1:0]   rtE,
  input  logic [REGW-1:0]   WriteRegE,
  input  logic [REGW-1:0]   WriteRegM,
  input  logic [REGW-1:0]   WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              bneD,
  input  logic              MduOpD,
  input  logic              MduStartE,
  input  logic [REGW-1:0]   MduRegE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              MduBusy,
`ifdef HAZARD_PERF_EN
  output logic              MduDoneW,
  output logic [PERF_W-1:0] StallCount
`else
  output logic              MduDoneW
`endif
);

  logic [REGW-1:0] mdu_reg;
  fwd_sel_e        fwd_a;
  fwd_sel_e        fwd_b;
  logic            lwstall;
  logic            branchstall;
  logic            mdustall;
  logic            stall;

  mdu_tracker #(
    .MDU_LAT (MDU_LAT),
    .REGW    (REGW)
  ) u_mdu_tracker (
    .clk     (clk),
    .rst_n   (reset_n),
    .start   (MduStartE),
    .dest    (MduRegE),
    .mdu_reg (mdu_reg),
    .busy    (MduBusy),
    .done    (MduDoneW)
  );

  // E-stage operand select: the younger M result wins over W.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (rsE != '0 && rsE == WriteRegM && RegWriteM)      fwd_a = FWD_M;
    else if (rsE != '0 && rsE == WriteRegW && RegWriteW) fwd_a = FWD_W;
    if (rtE != '0 && rtE == WriteRegM && RegWriteM)      fwd_b = FWD_M;
    else if (rtE != '0 && rtE == WriteRegW && RegWriteW) fwd_b = FWD_W;
  end

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;
  assign ForwardAD = (rsD != '0) && (rsD == WriteRegM) && RegWriteM;
  assign ForwardBD = (rtD != '0) && (rtD == WriteRegM) && RegWriteM;

  // Independent stall sources, simply ORed together.
  always_comb begin
    lwstall     = 1'b0;
    branchstall = 1'b0;
    mdustall    = 1'b0;
    lwstall = MemtoRegE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
    branchstall = (BranchD || bneD) &&
                  ((RegWriteE && (WriteRegE != '0) &&
                    ((WriteRegE == rsD) || (WriteRegE == rtD))) ||
                   (MemtoRegM && (WriteRegM != '0) &&
                    ((WriteRegM == rsD) || (WriteRegM == rtD))));
    mdustall = MduBusy &&
               (MduOpD || ((mdu_reg != '0) && ((rsD == mdu_reg) || (rtD == mdu_reg))));
  end

  assign stall  = lwstall || branchstall || mdustall;
  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

`ifdef HAZARD_PERF_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCount <= '0;
    end else if (stall && StallCount != '1) begin
      StallCount <= StallCount + PERF_W'(1);
    end
  end
`else
  if (PERF_W == 0) begin : g_bad_perf
    $error("hazard_scoreboard: PERF_W must be nonzero");
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default MDU_LAT=4).
module tb_hazard_scoreboard;

  localparam int unsigned REGW = 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [REGW-1:0] rsD, rtD, rsE, rtE;
  logic [REGW-1:0] WriteRegE, WriteRegM, WriteRegW, MduRegE;
  logic            RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic            BranchD, bneD, MduOpD, MduStartE;
  logic            ForwardAD, ForwardBD, StallF, StallD, FlushE, MduBusy, MduDoneW;
  logic [1:0]      ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [3:0]      StallCount;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
  hazard_scoreboard #(.PERF_W(4)) dut (
`else
  hazard_scoreboard dut (
`endif
    .clk(clk), .reset_n(reset_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .bneD(bneD),
    .MduOpD(MduOpD), .MduStartE(MduStartE), .MduRegE(MduRegE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .MduBusy(MduBusy),
`ifdef HAZARD_PERF_EN
    .MduDoneW(MduDoneW),
    .StallCount(StallCount)
`else
    .MduDoneW(MduDoneW)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // All three stall outputs must agree with the expected stall value.
  task automatic chk_stall(input string tag, input logic exp);
    chk(tag, {29'd0, StallF, StallD, FlushE}, {29'd0, exp, exp, exp});
  endtask

  task automatic clear();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0; MduRegE = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; bneD = 0; MduOpD = 0; MduStartE = 0;
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clear();
    reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(MduBusy), 32'd0);
    chk("rst_done", 32'(MduDoneW), 32'd0);
    chk_stall("rst_stall", 1'b0);
    tick(); tick();
    reset_n = 1'b1;

    // E-stage forwarding
    tick();
    rsE = 5; rtE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    #1;
    chk("fwdAE_m", 32'(ForwardAE), 32'd2);
    chk("fwdBE_m", 32'(ForwardBE), 32'd2);
    RegWriteM = 0; #1;
    chk("fwdAE_w", 32'(ForwardAE), 32'd1);
    rsE = 0; #1;
    chk("fwdAE_r0", 32'(ForwardAE), 32'd0);
    chk("fwdBE_w", 32'(ForwardBE), 32'd1);
    rsE = 5; RegWriteM = 1; WriteRegM = 6; #1;
    chk("fwdAE_w_mmiss", 32'(ForwardAE), 32'd1);
    RegWriteW = 0; #1;
    chk("fwdAE_none", 32'(ForwardAE), 32'd0);

    // D-stage compare forwarding
    clear(); rsD = 7; WriteRegM = 7; RegWriteM = 1; #1;
    chk("fwdAD", 32'(ForwardAD), 32'd1);
    chk("fwdBD_miss", 32'(ForwardBD), 32'd0);
    rtD = 7; rsD = 0; #1;
    chk("fwdBD", 32'(ForwardBD), 32'd1);
    chk("fwdAD_r0", 32'(ForwardAD), 32'd0);

    // Load-use stall
    tick(); clear();
    MemtoRegE = 1; rtE = 8; rsD = 8; #1;
    chk_stall("lw_rs", 1'b1);
    tick();
    MemtoRegE = 0; #1;
    chk_stall("lw_released", 1'b0);
    MemtoRegE = 1; rtE = 0; rsD = 0; #1;
    chk_stall("lw_rt0", 1'b0);
    rtE = 8; rtD = 8; rsD = 3; #1;
    chk_stall("lw_rt", 1'b1);

    // Branch stalls
    tick(); clear();
    BranchD = 1; RegWriteE = 1; WriteRegE = 3; rtD = 3; #1;
    chk_stall("br_alu_e", 1'b1);
    tick();
    RegWriteE = 0; WriteRegE = 0; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 3; #1;
    chk_stall("br_load_m", 1'b1);
    tick();
    MemtoRegM = 0; #1;
    chk_stall("br_released", 1'b0);
    chk("br_fwdBD", 32'(ForwardBD), 32'd1);
    BranchD = 0; bneD = 1; RegWriteE = 1; WriteRegE = 4; rsD = 4; #1;
    chk_stall("bne_alu_e", 1'b1);
    bneD = 0; #1;
    chk_stall("nobranch", 1'b0);

    // Multi-cycle op: dependent read of r9
    tick(); clear();
    MduStartE = 1; MduRegE = 9; rsD = 9; #1;
    chk_stall("mdu_issue", 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick(); MduStartE = 0; #1;
      chk_stall($sformatf("mdu_dep_c%0d", c), 1'b1);
      chk($sformatf("mdu_done_c%0d", c), 32'(MduDoneW), (c == 4) ? 32'd1 : 32'd0);
    end
    tick(); #1;
    chk_stall("mdu_dep_c5", 1'b0);
    chk("mdu_busy_c5", 32'(MduBusy), 32'd0);

    // Multi-cycle op: structural stall on MduOpD with unrelated regs
    clear(); MduStartE = 1; MduRegE = 9; MduOpD = 1; rsD = 1; rtD = 2; #1;
    chk_stall("mduop_idle", 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick(); MduStartE = 0; #1;
      chk_stall($sformatf("mduop_c%0d", c), 1'b1);
      if (c == 2) begin
        MduOpD = 0; #1;
        chk_stall("mdu_unrelated", 1'b0);
        MduOpD = 1;
      end
    end
    tick(); #1;
    chk_stall("mduop_c5", 1'b0);

    // Reissue exactly when the old op completes
    clear(); MduStartE = 1; MduRegE = 9;
    tick(); MduStartE = 0;
    tick(); tick(); tick();
    MduStartE = 1; MduRegE = 10; #1;
    chk("reissue_done_old", 32'(MduDoneW), 32'd1);
    tick(); MduStartE = 0; rsD = 10; #1;
    chk("reissue_busy", 32'(MduBusy), 32'd1);
    chk("reissue_done", 32'(MduDoneW), 32'd0);
    chk_stall("reissue_new_reg", 1'b1);
    rsD = 9; #1;
    chk_stall("reissue_old_reg", 1'b0);
    tick(); tick(); tick(); tick(); #1;
    chk("reissue_drained", 32'(MduBusy), 32'd0);

    // Reset while cnt==2 abandons the op
    clear(); MduStartE = 1; MduRegE = 9; rsD = 9;
    tick(); MduStartE = 0;
    tick(); tick(); #1;
    chk("pre_rst_busy", 32'(MduBusy), 32'd1);
    reset_n = 1'b0; #1;
    chk("mid_rst_busy", 32'(MduBusy), 32'd0);
    chk("mid_rst_done", 32'(MduDoneW), 32'd0);
    chk_stall("mid_rst_stall", 1'b0);
    tick(); reset_n = 1'b1;
    tick(); #1;
    chk("post_rst_done", 32'(MduDoneW), 32'd0);
    chk_stall("post_rst_stall", 1'b0);

`ifdef HAZARD_PERF_EN
    // Saturating stall counter
    clear(); reset_n = 1'b0; #1;
    chk("perf_rst", 32'(StallCount), 32'd0);
    tick(); reset_n = 1'b1;
    MemtoRegE = 1; rtE = 8; rsD = 8;
    for (int c = 0; c < 20; c++) tick();
    #1;
    chk("perf_sat", 32'(StallCount), 32'd15);
    tick(); #1;
    chk("perf_hold", 32'(StallCount), 32'd15);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
